fifo_drain_wb_dma: RTL
======================

// Module: fifo_drain_wb_dma
//
// PURPOSE
//   Read-side consumer for the synchronous 256x32 FIFO. Pops words from the
//   FIFO read port and writes them, one by one, to consecutive word addresses
//   over a Wishbone classic write-only master port.
//   Software programs a base address and a word count, then pulses start.
//   Status reports busy, done, aborted and the running word count.
//
// PARAMETERS
//   AW     24  Wishbone word-address width.
//   CNT_W  16  Width of the length and count fields; max transfer 2^CNT_W-1 words.
//
// PORTS
//   clk            in   1      clock, all logic on rising edge
//   rst            in   1      reset, asynchronous, active-high
//   cfg_base       in   AW     start word address, sampled on cfg_start
//   cfg_len        in   CNT_W  number of words to move, sampled on cfg_start
//   cfg_start      in   1      1-cycle start pulse
//   cfg_abort      in   1      level/pulse abort request
//   stat_busy      out  1      transfer in progress
//   stat_done      out  1      sticky: last transfer completed all words
//   stat_aborted   out  1      sticky: last transfer ended by abort
//   stat_count     out  CNT_W  words acknowledged on Wishbone in current/last transfer
//   fifo_rd_data   in   32     FIFO head word, valid when fifo_rd_empty=0
//   fifo_rd_empty  in   1      FIFO has no valid head word
//   fifo_rd_ena    out  1      pop FIFO head word this cycle
//   wb_adr         out  AW     word address
//   wb_dat_w       out  32     write data
//   wb_sel         out  4      constant 4'hf
//   wb_we          out  1      constant 1
//   wb_cyc         out  1      bus cycle
//   wb_stb         out  1      strobe, always equal to wb_cyc
//   wb_ack         in   1      slave acknowledge
//
// BEHAVIOUR
//   - Reset (async, immediate): state=IDLE; wb_cyc=wb_stb=0; wb_adr=0; wb_dat_w=0;
//     busy=done=aborted=0; stat_count=0. The FIFO is not flushed by this block.
//   - FSM has three states: IDLE, WAIT, WRITE.
//   - IDLE, busy=0:
//       * cfg_start: latch adr=cfg_base, rem=cfg_len; clear count, done, aborted.
//       * If cfg_len==0: set done=1 and stay in IDLE. Otherwise go to WAIT, busy=1.
//   - WAIT:
//       * fifo_rd_ena = (state==WAIT) & ~fifo_rd_empty & ~cfg_abort. This is
//         combinational and never asserted when the FIFO is empty.
//       * On a pop: wb_dat_w <= fifo_rd_data, then go to WRITE with cyc=stb=1
//         on the next cycle.
//       * cfg_abort in WAIT: no pop; go to IDLE; aborted=1.
//   - WRITE:
//       * cyc, stb, adr and dat stay stable until wb_ack.
//       * On ack: drop cyc/stb on the next edge; adr+1 (wraps modulo 2^AW);
//         rem-1; count+1.
//       * If rem==1: go to IDLE with done=1. Else go to WAIT, or to IDLE with
//         aborted=1 if cfg_abort is seen at or before the ack.
//       * Abort never drops an in-flight bus cycle. The popped word is always
//         written and counted.
//   - Throughput: at best 2 cycles per word (WAIT pop, then WRITE with a
//     same-cycle ack). No pop is issued while WRITE is pending.
//   - cfg_start while busy: ignored; the latched config is unchanged.
//   - Simultaneous cfg_start and cfg_abort in IDLE: start wins.
//   - done and aborted are mutually exclusive. Both clear on the next accepted start.
//   - Reset mid-transfer: the bus cycle is dropped immediately. Any word
//     already popped is lost.
//
// TESTING
//   1. FIFO preloaded with 4 words, base=0x100, len=4, ack tied to 1 ->
//      writes to 0x100..0x103 with the matching data; 2 cycles per word;
//      done=1, count=4, busy=0.
//   2. len=0 start -> done=1 the next cycle; no fifo_rd_ena, no wb_cyc.
//   3. Empty FIFO, len=3, words pushed 10 cycles apart -> busy held;
//      exactly 3 pops and 3 writes; never a pop while empty.
//   4. Ack delayed 5 cycles -> adr/dat/stb stable throughout; no pop during WRITE.
//   5. Abort asserted mid-WRITE of word 2 of 8 -> word 2 completes;
//      aborted=1, done=0, count=2; remaining FIFO words untouched.
//   6. base=0xFFFFFE, len=3 -> addresses 0xFFFFFE, 0xFFFFFF, 0x000000.
//      Separately: rst asserted while cyc=1 -> cyc=0 and busy=0 immediately.

Source files
------------

// File: rtl/fifo_drain_wb_dma.sv
// Drains words from a synchronous FIFO read port and writes them to consecutive
// word addresses through a write-only Wishbone classic master.
module fifo_drain_wb_dma #(
    parameter int AW    = 24,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    cfg_base,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    output logic             stat_busy,
    output logic             stat_done,
    output logic             stat_aborted,
    output logic [CNT_W-1:0] stat_count,
    input  logic [31:0]      fifo_rd_data,
    input  logic             fifo_rd_empty,
    output logic             fifo_rd_ena,
    output logic [AW-1:0]    wb_adr,
    output logic [31:0]      wb_dat_w,
    output logic [3:0]       wb_sel,
    output logic             wb_we,
    output logic             wb_cyc,
    output logic             wb_stb,
    input  logic             wb_ack
);

    typedef enum logic [1:0] {IDLE, WAIT, WRITE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [AW-1:0]    adr;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] count;
    logic [31:0]      dat;
    logic             done;
    logic             aborted;
    logic             abort_pend;
    logic             last_word;
    logic             abort_hit;

    assign last_word = (rem == CNT_W'(1));
    // An abort seen anywhere in the write phase, including the ack cycle itself
    assign abort_hit = abort_pend | cfg_abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cfg_start && (cfg_len != '0)) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cfg_abort) begin
                    state_nxt = IDLE;
                end else if (!fifo_rd_empty) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (wb_ack) begin
                    if (last_word || abort_hit) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stat_busy   = (state != IDLE);
        wb_cyc      = (state == WRITE);
        wb_stb      = (state == WRITE);
        fifo_rd_ena = (state == WAIT) & ~fifo_rd_empty & ~cfg_abort;
    end

    // Transfer bookkeeping; the in-flight word is always completed and counted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adr        <= '0;
            rem        <= '0;
            count      <= '0;
            dat        <= '0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        adr     <= cfg_base;
                        rem     <= cfg_len;
                        count   <= '0;
                        aborted <= 1'b0;
                        done    <= (cfg_len == '0);
                    end
                end
                WAIT: begin
                    if (cfg_abort) begin
                        aborted <= 1'b1;
                    end else if (!fifo_rd_empty) begin
                        dat        <= fifo_rd_data;
                        abort_pend <= 1'b0;
                    end
                end
                WRITE: begin
                    if (cfg_abort) begin
                        abort_pend <= 1'b1;
                    end
                    if (wb_ack) begin
                        adr   <= adr + 1'b1;
                        rem   <= rem - 1'b1;
                        count <= count + 1'b1;
                        if (last_word) begin
                            done <= 1'b1;
                        end else if (abort_hit) begin
                            aborted <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign stat_done    = done;
    assign stat_aborted = aborted;
    assign stat_count   = count;
    assign wb_adr       = adr;
    assign wb_dat_w     = dat;
    assign wb_sel       = 4'hf;
    assign wb_we        = 1'b1;

endmodule
